// File: rtl/mb_atm_controller_if.sv
// Signal bundle for the Multibanco ATM session controller.
//
// Signalling: there is no valid/ready pair. EN is a level-sensitive session
// qualifier; while a session is open the serial lines (SALDO, PIN, VAL) are
// sampled on every rising CLK edge spent in the matching shifting state, MSB
// first, and COD is sampled once in the operation-select state. All outputs are
// registered except PAR, which follows SALDO_OUT combinationally.
//
// Modports:
//   master - session driver: drives EN/PIN/COD/VAL/SALDO, observes outputs
//   slave  - the controller: samples inputs, drives outputs and dbg_state
interface mb_atm_controller_if;
  logic       EN;
  logic       PIN;
  logic       COD;
  logic       VAL;
  logic       SALDO;
  logic       COD_OUT;
  logic [3:0] VAL_OUT;
  logic [3:0] SALDO_OUT;
  logic [4:0] ECRA;
  logic       PAR;
  logic [3:0] dbg_state;

  modport master (
    output EN, PIN, COD, VAL, SALDO,
    input  COD_OUT, VAL_OUT, SALDO_OUT, ECRA, PAR, dbg_state
  );

  modport slave (
    input  EN, PIN, COD, VAL, SALDO,
    output COD_OUT, VAL_OUT, SALDO_OUT, ECRA, PAR, dbg_state
  );
endinterface

// File: rtl/mb_atm_controller.sv
// Multibanco ATM session controller.
//
// Flow: IDLE -> LOAD (4 serial balance bits) -> PIN_IN (4 serial PIN bits)
// -> CHECK -> SELECT -> {DONE (balance inquiry) | VAL_IN -> DISPENSE -> DONE}.
// Wrong PINs accumulate in a tries counter that survives aborted sessions;
// reaching MAX_TRIES locks the block in BLOCKED until RST.
//
// Ports:
//   CLK - system clock, rising edge
//   RST - synchronous reset, active high
//   bus - mb_atm_controller_if.slave (EN/PIN/COD/VAL/SALDO in;
//         COD_OUT/VAL_OUT/SALDO_OUT/ECRA/PAR/dbg_state out)
module mb_atm_controller #(
  parameter logic [3:0] PIN_CODE  = 4'b1010,
  parameter int         MAX_TRIES = 3
) (
  input logic                   CLK,
  input logic                   RST,
  mb_atm_controller_if.slave    bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_PIN_IN   = 4'd2;
  localparam logic [3:0] S_CHECK    = 4'd3;
  localparam logic [3:0] S_SELECT   = 4'd4;
  localparam logic [3:0] S_VAL_IN   = 4'd5;
  localparam logic [3:0] S_DISPENSE = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_BLOCKED  = 4'd8;

  localparam logic [4:0] M_WELCOME   = 5'd0;
  localparam logic [4:0] M_LOADING   = 5'd1;
  localparam logic [4:0] M_ENTER_PIN = 5'd2;
  localparam logic [4:0] M_WRONG_PIN = 5'd3;
  localparam logic [4:0] M_SELECT_OP = 5'd4;
  localparam logic [4:0] M_ENTER_VAL = 5'd5;
  localparam logic [4:0] M_DISPENSED = 5'd6;
  localparam logic [4:0] M_BALANCE   = 5'd7;
  localparam logic [4:0] M_NO_FUNDS  = 5'd8;
  localparam logic [4:0] M_BLOCKED   = 5'd9;

  localparam logic [2:0] TRIES_LIMIT = 3'(MAX_TRIES);

  logic [3:0] state;
  logic [1:0] bit_cnt;
  logic [2:0] tries;
  logic [2:0] tries_inc;
  logic [3:0] pin_sr;
  logic [3:0] amt_sr;
  logic [4:0] ecra;
  logic [3:0] val_out;
  logic [3:0] saldo_out;
  logic       cod_out;
  logic       in_session;

  assign tries_inc = tries + 3'd1;

  // States in which dropping EN abandons the session.
  assign in_session = (state == S_LOAD)   || (state == S_PIN_IN) ||
                      (state == S_CHECK)  || (state == S_SELECT) ||
                      (state == S_VAL_IN) || (state == S_DISPENSE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      bit_cnt   <= 2'd0;
      tries     <= 3'd0;
      pin_sr    <= 4'd0;
      amt_sr    <= 4'd0;
      ecra      <= M_WELCOME;
      val_out   <= 4'd0;
      saldo_out <= 4'd0;
      cod_out   <= 1'b0;
    end else if (in_session && !bus.EN) begin
      // Abort: clear outputs and partial data, but keep tries.
      state     <= S_IDLE;
      bit_cnt   <= 2'd0;
      pin_sr    <= 4'd0;
      amt_sr    <= 4'd0;
      ecra      <= M_WELCOME;
      val_out   <= 4'd0;
      saldo_out <= 4'd0;
      cod_out   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ecra      <= M_WELCOME;
          val_out   <= 4'd0;
          saldo_out <= 4'd0;
          cod_out   <= 1'b0;
          if (bus.EN) begin
            state   <= S_LOAD;
            ecra    <= M_LOADING;
            bit_cnt <= 2'd0;
          end
        end
        S_LOAD: begin
          saldo_out <= {saldo_out[2:0], bus.SALDO};
          bit_cnt   <= bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            state   <= S_PIN_IN;
            bit_cnt <= 2'd0;
            ecra    <= (tries != 3'd0) ? M_WRONG_PIN : M_ENTER_PIN;
          end
        end
        S_PIN_IN: begin
          pin_sr  <= {pin_sr[2:0], bus.PIN};
          bit_cnt <= bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (pin_sr == PIN_CODE) begin
            tries <= 3'd0;
            state <= S_SELECT;
            ecra  <= M_SELECT_OP;
          end else if (tries_inc == TRIES_LIMIT) begin
            tries     <= tries_inc;
            state     <= S_BLOCKED;
            ecra      <= M_BLOCKED;
            val_out   <= 4'd0;
            saldo_out <= 4'd0;
            cod_out   <= 1'b0;
          end else begin
            tries   <= tries_inc;
            state   <= S_PIN_IN;
            ecra    <= M_WRONG_PIN;
            bit_cnt <= 2'd0;
          end
        end
        S_SELECT: begin
          cod_out <= bus.COD;
          if (bus.COD) begin
            state <= S_DONE;
            ecra  <= M_BALANCE;
          end else begin
            state   <= S_VAL_IN;
            ecra    <= M_ENTER_VAL;
            bit_cnt <= 2'd0;
          end
        end
        S_VAL_IN: begin
          amt_sr  <= {amt_sr[2:0], bus.VAL};
          bit_cnt <= bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            state <= S_DISPENSE;
          end
        end
        S_DISPENSE: begin
          // The amount <= balance guard makes the subtraction underflow-free.
          if ((amt_sr != 4'd0) && (amt_sr <= saldo_out)) begin
            saldo_out <= saldo_out - amt_sr;
            val_out   <= amt_sr;
            ecra      <= M_DISPENSED;
          end else begin
            val_out <= 4'd0;
            ecra    <= M_NO_FUNDS;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          if (!bus.EN) begin
            state     <= S_IDLE;
            ecra      <= M_WELCOME;
            val_out   <= 4'd0;
            saldo_out <= 4'd0;
            cod_out   <= 1'b0;
          end
        end
        S_BLOCKED: begin
          ecra      <= M_BLOCKED;
          val_out   <= 4'd0;
          saldo_out <= 4'd0;
          cod_out   <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          ecra  <= M_WELCOME;
        end
      endcase
    end
  end

  assign bus.ECRA      = ecra;
  assign bus.VAL_OUT   = val_out;
  assign bus.SALDO_OUT = saldo_out;
  assign bus.COD_OUT   = cod_out;
  assign bus.PAR       = ^saldo_out;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mb_atm_controller.sv
// Directed bench for mb_atm_controller: session flows, insufficient funds,
// PIN retries/lockout, aborts and mid-session reset.
module tb_mb_atm_controller;

  logic CLK;
  logic RST;
  int   tests_run;
  int   tests_failed;
  logic [4:0] exp_q[$];

  mb_atm_controller_if bus ();

  mb_atm_controller #(
    .PIN_CODE  (4'b1010),
    .MAX_TRIES (3)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  // Driver tasks
  task automatic start_session();
    bus.EN = 1'b1;
    tick();
  endtask

  task automatic load_bal(input logic [3:0] b);
    for (int i = 3; i >= 0; i--) begin
      bus.SALDO = b[i];
      tick();
    end
  endtask

  // Shifts 4 PIN bits, then spends the CHECK cycle.
  task automatic enter_pin(input logic [3:0] p);
    for (int i = 3; i >= 0; i--) begin
      bus.PIN = p[i];
      tick();
    end
    tick();
  endtask

  task automatic select_op(input logic c);
    bus.COD = c;
    tick();
  endtask

  // Shifts 4 amount bits, then spends the DISPENSE cycle.
  task automatic enter_val(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) begin
      bus.VAL = v[i];
      tick();
    end
    tick();
  endtask

  task automatic end_session();
    bus.EN = 1'b0;
    tick();
  endtask

  task automatic withdraw(input string tag, input logic [3:0] bal, input logic [3:0] amt,
                          input logic [4:0] exp_ecra, input logic [3:0] exp_val,
                          input logic [3:0] exp_bal);
    start_session();
    load_bal(bal);
    enter_pin(4'b1010);
    select_op(1'b0);
    enter_val(amt);
    check_eq({tag, "_ecra"}, bus.ECRA, exp_ecra);
    check_eq({tag, "_val_out"}, bus.VAL_OUT, exp_val);
    check_eq({tag, "_saldo"}, bus.SALDO_OUT, exp_bal);
    check_eq({tag, "_par"}, bus.PAR, ^exp_bal);
    end_session();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    bus.EN = 1'b0; bus.PIN = 1'b0; bus.COD = 1'b0; bus.VAL = 1'b0; bus.SALDO = 1'b0;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    // Reset state
    check_eq("rst_ecra", bus.ECRA, 0);
    check_eq("rst_val", bus.VAL_OUT, 0);
    check_eq("rst_saldo", bus.SALDO_OUT, 0);
    check_eq("rst_cod", bus.COD_OUT, 0);
    check_eq("rst_par", bus.PAR, 0);

    // Full withdrawal: balance 9, withdraw 5
    start_session();
    check_eq("t1_loading", bus.ECRA, 1);
    load_bal(4'b1001);
    check_eq("t1_enter_pin", bus.ECRA, 2);
    check_eq("t1_saldo_loaded", bus.SALDO_OUT, 9);
    enter_pin(4'b1010);
    check_eq("t1_select", bus.ECRA, 4);
    select_op(1'b0);
    check_eq("t1_enter_val", bus.ECRA, 5);
    enter_val(4'b0101);
    check_eq("t1_ecra", bus.ECRA, 6);
    check_eq("t1_val_out", bus.VAL_OUT, 5);
    check_eq("t1_saldo", bus.SALDO_OUT, 4);
    check_eq("t1_par", bus.PAR, 1);
    check_eq("t1_cod", bus.COD_OUT, 0);
    tick();
    check_eq("t1_done_hold", bus.ECRA, 6);
    end_session();
    check_eq("t1_idle_ecra", bus.ECRA, 0);
    check_eq("t1_idle_val", bus.VAL_OUT, 0);
    check_eq("t1_idle_saldo", bus.SALDO_OUT, 0);

    // Balance inquiry: balance 9
    start_session();
    load_bal(4'd9);
    enter_pin(4'b1010);
    select_op(1'b1);
    check_eq("t2_ecra", bus.ECRA, 7);
    check_eq("t2_saldo", bus.SALDO_OUT, 9);
    check_eq("t2_par", bus.PAR, 0);
    check_eq("t2_cod", bus.COD_OUT, 1);
    check_eq("t2_val", bus.VAL_OUT, 0);
    end_session();

    // Funds boundaries
    withdraw("t3_over", 4'd3, 4'd7, 5'd8, 4'd0, 4'd3);
    withdraw("t3_zero", 4'd3, 4'd0, 5'd8, 4'd0, 4'd3);
    withdraw("t3_exact", 4'd3, 4'd3, 5'd6, 4'd3, 4'd0);
    withdraw("t3_max", 4'd15, 4'd14, 5'd6, 4'd14, 4'd1);

    // Lockout after three wrong PINs, scoreboarded screen sequence
    exp_q.push_back(5'd3);
    exp_q.push_back(5'd3);
    exp_q.push_back(5'd9);
    start_session();
    load_bal(4'd5);
    for (int k = 0; k < 3; k++) begin
      enter_pin(4'b0000);
      if (exp_q.size() == 0) begin
        check_eq("t4_queue_empty", 1, 0);
      end else begin
        check_eq($sformatf("t4_try%0d", k + 1), bus.ECRA, exp_q.pop_front());
      end
    end
    check_eq("t4_blk_saldo", bus.SALDO_OUT, 0);
    bus.EN = 1'b0;
    tick();
    check_eq("t4_en0", bus.ECRA, 9);
    bus.EN = 1'b1;
    tick();
    tick();
    check_eq("t4_en1", bus.ECRA, 9);
    check_eq("t4_blk_val", bus.VAL_OUT, 0);
    bus.EN = 1'b0;
    do_reset();
    check_eq("t4_rst", bus.ECRA, 0);

    // Wrong then correct clears tries
    start_session();
    load_bal(4'd6);
    enter_pin(4'b0011);
    check_eq("t5_wrong", bus.ECRA, 3);
    enter_pin(4'b1010);
    check_eq("t5_right", bus.ECRA, 4);
    end_session();
    start_session();
    load_bal(4'd6);
    check_eq("t5_fresh_prompt", bus.ECRA, 2);
    enter_pin(4'b1111);
    check_eq("t5_w1", bus.ECRA, 3);
    enter_pin(4'b0000);
    check_eq("t5_w2_not_blocked", bus.ECRA, 3);
    end_session();
    check_eq("t5_abort_idle", bus.ECRA, 0);

    // Tries survive abort; abort mid-PIN
    start_session();
    load_bal(4'd6);
    check_eq("t6_kept_tries", bus.ECRA, 3);
    bus.PIN = 1'b1; tick();
    bus.PIN = 1'b0; tick();
    bus.EN = 1'b0;
    tick();
    check_eq("t6_abort_ecra", bus.ECRA, 0);
    check_eq("t6_abort_saldo", bus.SALDO_OUT, 0);
    check_eq("t6_abort_state", bus.dbg_state, 0);

    // Reset during VAL_IN
    do_reset();
    start_session();
    load_bal(4'd8);
    enter_pin(4'b1010);
    select_op(1'b0);
    bus.VAL = 1'b1; tick();
    bus.VAL = 1'b0; tick();
    RST = 1'b1;
    tick();
    check_eq("t6_rst_ecra", bus.ECRA, 0);
    check_eq("t6_rst_saldo", bus.SALDO_OUT, 0);
    check_eq("t6_rst_val", bus.VAL_OUT, 0);
    check_eq("t6_rst_cod", bus.COD_OUT, 0);
    RST = 1'b0;
    bus.EN = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mb_atm_controller.md
Name: mb_atm_controller

Overview:
- Synchronous controller for a simplified Multibanco (ATM) session: card-present enable, serial balance load, serial 4-bit PIN check with a retry limit, operation select, and serial withdrawal amount.
- Drives a 5-bit screen message code, the dispensed amount, the updated balance and a parity bit for the balance.
- Top-level block of the ATM project; all data inputs are 1-bit serial lines, MSB first.

Parameters:
- PIN_CODE, 4'b1010, correct account PIN.
- MAX_TRIES, 3, wrong-PIN attempts allowed before lockout (range 1..7).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active high.
- EN  input  1  card inserted / session enable; level sensitive.
- PIN  input  1  serial PIN bit, MSB first.
- COD  input  1  operation select: 0 = withdrawal, 1 = balance inquiry.
- COD_OUT  output  1  latched operation code.
- VAL  input  1  serial withdrawal amount bit, MSB first.
- VAL_OUT  output  4  dispensed amount.
- SALDO  input  1  serial account balance bit, MSB first.
- SALDO_OUT  output  4  current balance register.
- ECRA  output  5  screen message code, binary.
- PAR  output  1  even parity of SALDO_OUT: XOR of its 4 bits.

Behaviour:
- All state, counters and outputs are registered. PAR is combinational from SALDO_OUT.
- RST=1 at an edge puts the block in this state:
  - state IDLE; ECRA=0; VAL_OUT=0; SALDO_OUT=0; COD_OUT=0; tries=0; bit counter=0.
- ECRA codes:
  - 0 WELCOME, 1 LOADING, 2 ENTER_PIN, 3 WRONG_PIN, 4 SELECT_OP.
  - 5 ENTER_VAL, 6 DISPENSED, 7 SHOW_BALANCE, 8 NO_FUNDS, 9 BLOCKED.
  - 10..31 are unused.
- IDLE (ECRA=0):
  - VAL_OUT, SALDO_OUT and COD_OUT are held at 0.
  - EN=1 sampled at an edge -> LOAD.
- LOAD (ECRA=1): SALDO is shifted into the balance register on 4 consecutive edges, MSB first. After the 4th bit -> PIN_IN.
- PIN_IN (ECRA=2, or 3 if tries>0): PIN is shifted into a 4-bit register on 4 consecutive edges. After the 4th bit -> CHECK.
- CHECK (1 cycle, ECRA unchanged):
  - Entered PIN equals PIN_CODE: tries cleared, -> SELECT.
  - Otherwise tries+1. If the new tries equals MAX_TRIES -> BLOCKED, else -> PIN_IN with ECRA=3.
- SELECT (ECRA=4): COD sampled once; COD_OUT is loaded with it.
  - COD=1 -> DONE with ECRA=7.
  - COD=0 -> VAL_IN.
- VAL_IN (ECRA=5): VAL is shifted in on 4 edges, MSB first, then -> DISPENSE.
- DISPENSE (1 cycle):
  - Amount is nonzero and amount <= balance: balance -= amount, VAL_OUT=amount, ECRA=6.
  - Otherwise: balance unchanged, VAL_OUT=0, ECRA=8.
  - Either way -> DONE. Subtraction is unsigned 4-bit and cannot underflow.
- DONE: all outputs hold. EN=0 -> IDLE.
- BLOCKED (ECRA=9): all other outputs forced to 0.
  - EN is ignored; only RST exits.
  - The tries counter is kept until RST.
- EN=0 sampled in LOAD, PIN_IN, CHECK, SELECT, VAL_IN or DISPENSE aborts the session:
  - -> IDLE at that edge; outputs cleared; partial shift data discarded.
  - The tries counter is kept, so wrong attempts accumulate across aborted sessions until a correct PIN or RST.
- Bit counter: 2 bits, reset to 0 on entry to every shifting state.
- Reset has priority over every transition, including mid-shift.
- SALDO_OUT shows the balance register from LOAD onward, including partial shifts.

Test Plan:
- Reset, then EN=1; SALDO bits 1,0,0,1; PIN 1,0,1,0; COD=0; VAL 0,1,0,1 -> ECRA=6, VAL_OUT=5, SALDO_OUT=4, PAR=1, COD_OUT=0. EN=0 -> next cycle ECRA=0, all outputs 0.
- Balance 9, correct PIN, COD=1 -> ECRA=7, SALDO_OUT=9, PAR=0, COD_OUT=1, VAL_OUT=0.
- Balance 3, withdraw 7 -> ECRA=8, VAL_OUT=0, SALDO_OUT=3. Withdraw 0 -> ECRA=8. Withdraw 3 -> ECRA=6, SALDO_OUT=0, PAR=0.
- Three consecutive wrong PINs (0000) -> ECRA=3 after the 1st and 2nd attempts, ECRA=9 after the 3rd. Toggling EN has no effect; RST -> ECRA=0.
- Wrong PIN, then correct PIN -> ECRA goes 3, then 4; the tries counter is cleared, which is checked by two later wrong attempts not blocking.
- EN dropped after 2 PIN bits -> IDLE the next cycle. RST asserted during VAL_IN -> all outputs 0 and ECRA=0 on that edge.
